// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: valid/ready sequencer around the pipelined FFT core, with flush padding/draining.
// Define FFT_FRAME_CTRL_STATS_EN to add the o_stall_cnt / o_frame_cnt statistics ports.
//
// state | meaning
// RUN   | forward input samples to the core on each handshake
// PAD   | inject zeros until the partial input frame is complete
// DRAIN | inject zeros until every pending frame has been output
module fft_frame_ctrl #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 16,
    parameter int LGSIZE = 11,
    parameter int PWIDTH = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*IWIDTH-1:0] s_data,
    input  logic                i_flush,
    output logic                fft_ce,
    output logic [2*IWIDTH-1:0] fft_sample,
    input  logic [2*OWIDTH-1:0] fft_result,
    input  logic                fft_sync,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*OWIDTH-1:0] m_data,
    output logic                m_last,
    output logic                o_busy,
    output logic                o_err
`ifdef FFT_FRAME_CTRL_STATS_EN
    ,
    output logic [31:0]         o_stall_cnt,
    output logic [31:0]         o_frame_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LGSIZE-1:0] LAST_BIN = '1;

    state_t              state;
    state_t              state_nxt;
    logic [LGSIZE-1:0]   in_cnt;
    logic [LGSIZE-1:0]   out_cnt;
    logic [PWIDTH-1:0]   pending;
    logic [PWIDTH-1:0]   pending_nxt;
    logic                started;
    logic                r_pend;
    logic                out_ok;
    logic                accept;
    logic                discard;
    logic                frame_in;
    logic                frame_out;

    // A core output is outstanding while r_pend is set; the core may only
    // advance once that output has been taken (or discarded before sync).
    assign out_ok    = !r_pend || m_ready;
    assign m_valid   = r_pend && (started || fft_sync);
    assign m_data    = fft_result;
    assign m_last    = m_valid && (out_cnt == LAST_BIN);
    assign accept    = m_valid && m_ready;
    assign discard   = r_pend && !m_valid;
    assign frame_in  = fft_ce && (in_cnt == LAST_BIN);
    assign frame_out = accept && m_last;
    assign o_busy    = (state != RUN) || (pending != '0);

    always_comb begin
        fft_ce      = 1'b0;
        s_ready     = 1'b0;
        fft_sample  = '0;
        state_nxt   = state;
        pending_nxt = pending;

        case ({frame_in, frame_out})
            2'b10:   pending_nxt = pending + PWIDTH'(1);
            2'b01:   pending_nxt = pending - PWIDTH'(1);
            default: pending_nxt = pending;
        endcase

        if (state == RUN) begin
            fft_sample = s_data;
        end

        if (!i_reset) begin
            case (state)
                RUN: begin
                    s_ready = out_ok;
                    fft_ce  = s_valid && out_ok;
                    if (i_flush) begin
                        if (in_cnt != '0) begin
                            state_nxt = PAD;
                        end else if (pending != '0) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                PAD: begin
                    fft_ce = out_ok;
                    if (frame_in) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    fft_ce = out_ok;
                    if (pending_nxt == '0) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= RUN;
            in_cnt  <= '0;
            out_cnt <= '0;
            pending <= '0;
            started <= 1'b0;
            r_pend  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (fft_ce) begin
                in_cnt <= in_cnt + LGSIZE'(1);
            end
            if (fft_ce) begin
                r_pend <= 1'b1;
            end else if (accept || discard) begin
                r_pend <= 1'b0;
            end
            if (fft_sync && r_pend) begin
                started <= 1'b1;
            end
            // A sync mid-frame means the output count drifted: realign so the
            // sync beat itself is bin 0.
            if (accept) begin
                if (fft_sync && (out_cnt != '0)) begin
                    o_err   <= 1'b1;
                    out_cnt <= LGSIZE'(1);
                end else begin
                    out_cnt <= out_cnt + LGSIZE'(1);
                end
            end
        end
    end

`ifdef FFT_FRAME_CTRL_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_cnt <= '0;
            o_frame_cnt <= '0;
        end else begin
            if ((state == RUN) && s_valid && !s_ready && (o_stall_cnt != '1)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            if (frame_out && (o_frame_cnt != '1)) begin
                o_frame_cnt <= o_frame_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl with an N=8 stub core (delay line plus sync); scoreboard of
// samples fed to the core versus samples accepted at the output, plus directed scenarios.
module tb_fft_frame_ctrl;
    localparam int N      = 8;
    localparam int LMAX   = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        i_flush;
    logic        fft_ce;
    logic [31:0] fft_sample;
    logic [31:0] fft_result;
    logic        fft_sync;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        o_busy;
    logic        o_err;
`ifdef FFT_FRAME_CTRL_STATS_EN
    logic [31:0] o_stall_cnt;
    logic [31:0] o_frame_cnt;
`endif

    fft_frame_ctrl #(.IWIDTH(16), .OWIDTH(16), .LGSIZE(3), .PWIDTH(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .i_flush(i_flush),
        .fft_ce(fft_ce), .fft_sample(fft_sample),
        .fft_result(fft_result), .fft_sync(fft_sync),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_busy(o_busy), .o_err(o_err)
`ifdef FFT_FRAME_CTRL_STATS_EN
        , .o_stall_cnt(o_stall_cnt), .o_frame_cnt(o_frame_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Stub core: output is the sample entered (tap+1) enables ago; sync marks ce index % N == 0.
    logic [3:0]  tap;
    bit          force_en;
    logic [31:0] dl_data [LMAX];
    int          dl_idx  [LMAX];
    logic        dl_vld  [LMAX];
    int          ce_idx;

    always @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LMAX; i++) begin
                dl_data[i] <= 32'hBAD0_BAD0;
                dl_idx[i]  <= 0;
                dl_vld[i]  <= 1'b0;
            end
            ce_idx <= 0;
        end else if (fft_ce) begin
            dl_data[0] <= fft_sample;
            dl_idx[0]  <= ce_idx;
            dl_vld[0]  <= 1'b1;
            ce_idx     <= ce_idx + 1;
            for (int i = 1; i < LMAX; i++) begin
                dl_data[i] <= dl_data[i-1];
                dl_idx[i]  <= dl_idx[i-1];
                dl_vld[i]  <= dl_vld[i-1];
            end
        end
    end

    always_comb begin
        fft_result = dl_data[tap];
        fft_sync   = dl_vld[tap] && (((dl_idx[tap] % N) == 0) || (force_en && dl_idx[tap] == 3));
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every sample handed to the core must come out once, in order; bins count modulo N.
    logic [31:0] exp_q [$];
    int  ce_total, lasts, acc_cnt, mdl_cnt, pend_max, zero_ce, first_last;
    bit  mdl_err, forced_seen, stream_mode, rst_prev, stall_prev;
    logic [31:0] prev_data;

    always @(negedge i_clk) begin
        int  pend;
        bit  exp_last;
        if (i_reset) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_fft_ce", fft_ce, 0);
            if (rst_prev) begin
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_o_err", o_err, 0);
                chk("rst_o_busy", o_busy, 0);
            end
            exp_q.delete();
            ce_total = 0; lasts = 0; acc_cnt = 0; mdl_cnt = 0; pend_max = 0;
            zero_ce = 0; first_last = -1; mdl_err = 0; forced_seen = 0;
            stall_prev = 0; rst_prev = 1;
        end else begin
            if (rst_prev) begin
                chk("post_rst_m_valid", m_valid, 0);
                chk("post_rst_o_busy", o_busy, 0);
            end
            rst_prev = 0;
            chk("o_err", o_err, mdl_err);
            pend = ce_total / N - lasts;
            if (stream_mode) begin
                chk("o_busy", o_busy, pend != 0);
                chk("ce_vs_handshake", fft_ce, s_valid && s_ready);
                if (fft_ce) chk("ce_sample", fft_sample, s_data);
            end
            if (!m_valid) chk("m_last_idle", m_last, 0);
            if (m_valid && !m_ready) begin
                chk("stall_ce", fft_ce, 0);
                chk("stall_s_ready", s_ready, 0);
            end
            if (stall_prev && m_valid) chk("stall_hold", m_data, prev_data);
            if (fft_ce) begin
                exp_q.push_back(fft_sample);
                ce_total++;
                if (fft_sample == 32'd0) zero_ce++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_data: accept with no sample outstanding, got %0h", m_data);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
                exp_last = (mdl_cnt == N - 1);
                chk("m_last", m_last, exp_last);
                if (exp_last) begin
                    lasts++;
                    if (forced_seen && first_last < 0) first_last = acc_cnt;
                end
                if (fft_sync && mdl_cnt != 0) begin
                    if (force_en && mdl_cnt == 3) forced_seen = 1;
                    mdl_err = 1;
                    mdl_cnt = 1;
                end else begin
                    mdl_cnt = (mdl_cnt + 1) % N;
                end
                acc_cnt++;
            end
            pend = ce_total / N - lasts;
            if (pend > pend_max) pend_max = pend;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    function automatic logic [31:0] ramp(input int k);
        return {16'(k + 257), 16'(k + 40960)};
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        s_valid = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic stream(input int n, input bit toggle, input int tail);
        int k = 0;
        int t = 0;
        int idle = 0;
        while ((k < n || idle < tail) && t < 3000) begin
            s_valid = (k < n);
            s_data  = ramp(k);
            m_ready = toggle ? ((t % 4) == 0 || (t % 4) == 3) : 1'b1;
            @(negedge i_clk);
            if (s_valid && s_ready) k++;
            @(posedge i_clk); #1;
            t++;
            if (k >= n && !s_valid) idle++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("stream_sent", k, n);
    endtask

    task automatic start_flush();
        int w = 0;
        stream_mode = 0;
        stream(11, 0, 0);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        w = 0;
    endtask

    initial begin
        int w;
        int lasts0;
`ifdef FFT_FRAME_CTRL_STATS_EN
        logic [31:0] c0;
`endif
        i_reset = 1'b1; s_valid = 0; s_data = 0; i_flush = 0; m_ready = 1;
        tap = 4'd9; force_en = 0; stream_mode = 1; rst_prev = 0;
        #1;
        do_reset();

        // Flush with nothing pending is ignored.
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        @(posedge i_clk); #1;
        chk("idle_flush_busy", o_busy, 0);

        // Continuous stream, latency 10.
        stream(32, 0, 20);
        chk("t1_accepts", acc_cnt, 23);
        chk("t1_lasts", lasts, 2);
        chk("t1_pend_peak", pend_max, 2);
        chk("t1_busy_end", o_busy, 1);
        chk("t1_err", o_err, 0);

        // Output backpressure pattern 1,0,0,1.
        do_reset();
        stream(32, 1, 20);
        chk("t2_accepts", acc_cnt, 23);
        chk("t2_lasts", lasts, 2);

        // Flush after 11 samples, latency 5: 5 pads then drain until pending empties.
        i_reset = 1'b1; tap = 4'd4;
        do_reset();
        start_flush();
        w = 0;
        while (o_busy && w < 200) begin @(negedge i_clk); w++; end
        chk("flush_busy_fall", o_busy, 0);
        @(negedge i_clk);
        chk("flush_run_s_ready", s_ready, 1);
        repeat (5) @(posedge i_clk);
        #1;
        chk("flush_zero_ces", zero_ce, 10);
        chk("flush_lasts", lasts, 2);
        chk("flush_ce_total", ce_total, 21);

        // Reset in the middle of DRAIN, then a fresh stream must be frame aligned.
        do_reset();
        start_flush();
        w = 0;
        while (zero_ce < 7 && w < 200) begin @(negedge i_clk); w++; end
        chk("drain_reached", zero_ce, 7);
        @(posedge i_clk); #1;
        do_reset();
        stream_mode = 1;
        stream(16, 0, 12);
        chk("t5_accepts", acc_cnt, 12);
        chk("t5_lasts", lasts, 1);

        // Spurious sync at bin 3 (and the genuine one at sample 8 then arrives mid-frame).
        tap = 4'd9;
        do_reset();
        force_en = 1;
        stream(32, 0, 20);
        force_en = 0;
        chk("t6_err_sticky", o_err, 1);
        chk("t6_first_last", first_last, 15);
        chk("t6_accepts", acc_cnt, 23);
        do_reset();
        @(posedge i_clk); #1;
        chk("t6_err_cleared", o_err, 0);

`ifdef FFT_FRAME_CTRL_STATS_EN
        do_reset();
        stream(20, 0, 0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = ramp(20);
        c0 = o_stall_cnt;
        repeat (5) begin @(posedge i_clk); #1; end
        chk("stat_stall", o_stall_cnt - c0, 5);
        m_ready = 1'b1;
        s_valid = 1'b0;
        stream(20, 0, 12);
        chk("stat_frames", o_frame_cnt, 3);
        chk("stat_frames_model", o_frame_cnt, lasts);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
